multiword_add_ctrl: RTL and testbench

- Sequencer that adds or subtracts two wide operands (W*N bits) by time-multiplexing one W-bit ripple-carry slice over N cycles, least-significant word first.
- The carry between words is held in a flop.
- Sits between a valid/ready producer and consumer, so wide arithmetic costs one W-bit adder instead of a W*N-bit ripple chain.

---
 rtl/multiword_add_ctrl_pkg.sv | 11 +
 rtl/multiword_add_ctrl_if.sv | 28 ++
 rtl/multiword_add_ctrl_rca_slice.sv | 23 ++
 rtl/multiword_add_ctrl.sv | 105 ++++++++++
 tb/tb_multiword_add_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multiword_add_ctrl_pkg.sv
// Shared types and helpers for the word-serial wide adder/subtractor.
package multiword_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // The word index needs at least one bit, even when N=1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_ctrl_if.sv
// Operand/result handshake bundle between producer, adder sequencer and consumer.
interface multiword_add_ctrl_if #(
  parameter int W = 32,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] a;
  logic [W*N-1:0] b;
  logic           cin;
  logic           sub;
  logic           out_valid;
  logic           out_ready;
  logic [W*N-1:0] sum;
  logic           cout;
  logic           ovf;
  logic           busy;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/multiword_add_ctrl_rca_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module rca_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[W];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Word-serial W*N-bit add/subtract: one shared W-bit slice, LSW first, carry held in a flop.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multiword_add_ctrl_if.slave bus
);

  localparam int IW = idx_width(N);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W*N-1:0] op_a_q, op_a_d;
  logic [W*N-1:0] op_b_q, op_b_d;
  logic [W*N-1:0] sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   a_word, b_word, slice_sum;
  logic           slice_cout;

  assign a_word = op_a_q[idx_q*W +: W];
  assign b_word = op_b_q[idx_q*W +: W];

  rca_slice #(.W(W)) u_slice (
    .a_i    (a_word),
    .b_i    (b_word),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is a + ~b + 1, so the +1 rides in on the initial carry.
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*W +: W] = slice_sum;
        carry_d             = slice_cout;
        if (idx_q == IW'(N - 1)) begin
          cout_d  = slice_cout;
          ovf_d   = (op_a_q[W*N-1] == op_b_q[W*N-1]) & (slice_sum[W-1] != op_a_q[W*N-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench for multiword_add_ctrl: driver pushes model results, monitor pops on handshake.
module tb_multiword_add_ctrl;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int WN = W * N;

  typedef struct {
    logic [WN-1:0] sum;
    logic          cout;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prev_ov = 1'b0;

  exp_t exp_q[$];
  int   acc_q[$];

  multiword_add_ctrl_if #(.W(W), .N(N)) bus ();

  multiword_add_ctrl #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned wrap for sum/cout, exact signed range test for ovf.
  function automatic exp_t model(input logic [WN-1:0] a, input logic [WN-1:0] b,
                                 input logic c, input logic s);
    exp_t r;
    logic signed [WN+1:0] sa, sb, ex;
    if (s) begin
      r.sum  = a - b;
      r.cout = (a >= b);
    end else begin
      {r.cout, r.sum} = {1'b0, a} + {1'b0, b} + {{WN{1'b0}}, c};
    end
    sa = $signed({{2{a[WN-1]}}, a});
    sb = $signed({{2{b[WN-1]}}, b});
    ex = s ? (sa - sb) : (sa + sb + $signed({{(WN+1){1'b0}}, c}));
    r.ovf = (ex[WN+1:WN-1] != 3'b000) && (ex[WN+1:WN-1] != 3'b111);
    return r;
  endfunction

  task automatic chk(input string name, input logic [WN-1:0] act, input logic [WN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [WN-1:0] a, input logic [WN-1:0] b,
                      input logic c, input logic s, output int acc);
    bus.a = a; bus.b = b; bus.cin = c; bus.sub = s;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin
        exp_q.push_back(model(a, b, c, s));
        acc = cyc + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no-accept required=accept");
    end else begin
      $display("ISSUE a=%h b=%h cin=%0d sub=%0d edge=%0d", a, b, c, s, acc);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: latency check on out_valid rise, scoreboard pop on handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL latency actual=unexpected-valid required=none");
        end else begin
          int t;
          t = acc_q.pop_front();
          chk("latency", WN'(cyc), WN'(t + N));
        end
      end
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard actual=extra-result required=none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("RESULT sum=%h cout=%0d ovf=%0d", bus.sum, bus.cout, bus.ovf);
          chk("sum", bus.sum, e.sum);
          chk("cout", WN'(bus.cout), WN'(e.cout));
          chk("ovf", WN'(bus.ovf), WN'(e.ovf));
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    logic [WN-1:0] ones, maxpos, minneg, ra, rb, hold_a, hold_b;
    exp_t e;
    int acc, acc1, acc2, acc3;
    bit seen;

    ones   = '1;
    maxpos = {1'b0, {(WN-1){1'b1}}};
    minneg = {1'b1, {(WN-1){1'b0}}};
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", WN'(bus.out_valid), '0);
    chk("rst_busy", WN'(bus.busy), '0);
    chk("rst_sum", bus.sum, '0);
    chk("rst_cout", WN'(bus.cout), '0);
    chk("rst_ovf", WN'(bus.ovf), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", WN'(bus.in_ready), WN'(1));

    // Directed arithmetic corners.
    send(ones, WN'(1), 1'b0, 1'b0, acc);
    send(WN'(5), WN'(7), 1'b0, 1'b1, acc);
    send(WN'(7), WN'(5), 1'b0, 1'b1, acc);
    send(maxpos, WN'(1), 1'b0, 1'b0, acc);
    send(minneg, WN'(1), 1'b0, 1'b1, acc);
    drain();

    // Backpressure: result held, second request ignored until consumer accepts.
    hold_a = {4{32'h1234_5678}};
    hold_b = {4{32'h9ABC_DEF0}};
    e = model(hold_a, hold_b, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    send(hold_a, hold_b, 1'b1, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1; else @(negedge clk);
    end
    chk("bp_valid_seen", WN'(seen), WN'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sum", bus.sum, e.sum);
      chk("bp_cout", WN'(bus.cout), WN'(e.cout));
      chk("bp_ovf", WN'(bus.ovf), WN'(e.ovf));
      chk("bp_in_ready", WN'(bus.in_ready), '0);
      chk("bp_out_valid", WN'(bus.out_valid), WN'(1));
      if (i == 3) begin
        bus.a = WN'(100); bus.b = WN'(200); bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", WN'(bus.in_ready), WN'(1));
    chk("bp_release_valid", WN'(bus.out_valid), '0);
    send(WN'(100), WN'(200), 1'b0, 1'b0, acc);
    drain();

    // Asynchronous reset while the third word is being processed.
    send({4{32'hDEAD_BEEF}}, {4{32'h0101_0101}}, 1'b0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", WN'(bus.out_valid), '0);
    chk("mid_rst_sum", bus.sum, '0);
    chk("mid_rst_busy", WN'(bus.busy), '0);
    exp_q.delete();
    acc_q.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", WN'(bus.in_ready), WN'(1));
    send(WN'(3), WN'(4), 1'b0, 1'b0, acc);
    drain();

    // Back-to-back issue with the consumer always ready.
    send(WN'(11), WN'(22), 1'b1, 1'b0, acc1);
    send(WN'(50), WN'(60), 1'b0, 1'b1, acc2);
    send(ones, ones, 1'b1, 1'b0, acc3);
    chk("b2b_spacing_1", WN'(acc2 - acc1), WN'(N + 2));
    chk("b2b_spacing_2", WN'(acc3 - acc2), WN'(N + 2));
    drain();

    // Randomized operands mixing full-width values with sign/borrow corners.
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: begin
          ra = {$urandom(), $urandom(), $urandom(), $urandom()};
          rb = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        1: begin
          ra = WN'($urandom_range(0, 15));
          rb = WN'($urandom_range(0, 15));
        end
        2: begin
          ra = ($urandom_range(0, 1) != 0) ? maxpos : minneg;
          rb = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        default: begin
          ra = {$urandom(), 96'h0};
          rb = ra;
        end
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
